// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
//   state_t : FSM state encoding for seq_mult_w
//   OP_ADD / OP_SUB : operation select for addsub_ext
package seq_mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_ext.sv
// (WIDTH+1)-bit adder/subtractor with per-operation sign- or zero-extension.
// Ports:
//   a, b    in  WIDTH    operands
//   op      in  1        OP_ADD or OP_SUB
//   sgn     in  1        1 = sign-extend operands, 0 = zero-extend
//   result  out WIDTH+1  ext(a) +/- ext(b); MSB is carry (unsigned) or sign (signed)
module addsub_ext
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             sgn,
    output logic [WIDTH:0]   result
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;

    assign a_ext  = {sgn & a[WIDTH-1], a};
    assign b_ext  = {sgn & b[WIDTH-1], b};
    assign result = (op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);

endmodule

// File: rtl/seq_mult_w.sv
// Sequential shift-add multiplier, signed or unsigned per operation.
// X:A:B shift chain retires one multiplier bit per ADD/SHIFT iteration.
// Optional build macro: SEQ_MULT_SKIP_EN - skip the ADD state when the
// current multiplier bit is 0 (data-dependent latency, same result).
// Ports:
//   Clk, Reset               clock, async active-low reset
//   Start, Abort             host request / synchronous cancel
//   Signed_Mode              operand interpretation, latched at Start
//   Multiplicand, Multiplier operands, latched at Start
//   Busy, Done               status (Done is a level held in DONE)
//   X                        sign/carry extension bit
//   Product                  {A,B} captured at completion
//   Aval, Bval               live A and B registers
//
// state | meaning
// IDLE  | waiting for Start
// LOAD  | clear accumulator and counter
// ADD   | conditionally add (or subtract on signed last bit) S into X:A
// SHIFT | shift X:A:B right one bit, advance counter
// DONE  | result valid, waiting for Start or Abort
module seq_mult_w
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Abort,
    input  logic               Signed_Mode,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic               Busy,
    output logic               Done,
    output logic               X,
    output logic [2*WIDTH-1:0] Product,
    output logic [WIDTH-1:0]   Aval,
    output logic [WIDTH-1:0]   Bval
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state, state_next;
    logic [WIDTH-1:0]   s_reg, a_reg, b_reg;
    logic               x_reg, mode_reg, done_reg;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod_reg;
    logic [WIDTH:0]     sum;
    logic               op_sel;

    // Signed operands: the MSB of the multiplier carries weight -2^(W-1),
    // so the final partial product is subtracted.
    assign op_sel = (mode_reg && (cnt == LAST_ITER)) ? OP_SUB : OP_ADD;

    addsub_ext #(.WIDTH(WIDTH)) u_addsub (
        .a      (a_reg),
        .b      (s_reg),
        .op     (op_sel),
        .sgn    (mode_reg),
        .result (sum)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (Start) state_next = LOAD;
            end
            LOAD: begin
`ifdef SEQ_MULT_SKIP_EN
                state_next = b_reg[0] ? ADD : SHIFT;
`else
                state_next = ADD;
`endif
            end
            ADD: state_next = SHIFT;
            SHIFT: begin
                if (cnt == LAST_ITER) begin
                    state_next = DONE;
                end else begin
`ifdef SEQ_MULT_SKIP_EN
                    // b_reg[1] becomes B[0] after this shift
                    state_next = b_reg[1] ? ADD : SHIFT;
`else
                    state_next = ADD;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
        if (Abort) state_next = IDLE;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s_reg    <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            x_reg    <= 1'b0;
            mode_reg <= 1'b0;
            cnt      <= '0;
            done_reg <= 1'b0;
            prod_reg <= '0;
        end else if (Abort) begin
            a_reg    <= '0;
            b_reg    <= '0;
            x_reg    <= 1'b0;
            cnt      <= '0;
            done_reg <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        s_reg    <= Multiplicand;
                        b_reg    <= Multiplier;
                        mode_reg <= Signed_Mode;
                        done_reg <= 1'b0;
                    end
                end
                LOAD: begin
                    a_reg <= '0;
                    x_reg <= 1'b0;
                    cnt   <= '0;
                end
                ADD: begin
                    if (b_reg[0]) {x_reg, a_reg} <= sum;
                end
                SHIFT: begin
                    a_reg <= {x_reg, a_reg[WIDTH-1:1]};
                    b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
                    // Signed: X holds the sign and is replicated. Unsigned: X is
                    // a carry that has now moved into A, so it must clear or a
                    // stale carry would re-enter on the next skipped add.
                    x_reg <= mode_reg & x_reg;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        done_reg <= 1'b1;
                        prod_reg <= {x_reg, a_reg, b_reg[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy    = (state == LOAD) || (state == ADD) || (state == SHIFT);
    assign Done    = done_reg;
    assign X       = x_reg;
    assign Product = prod_reg;
    assign Aval    = a_reg;
    assign Bval    = b_reg;

endmodule

// File: tb/tb_seq_mult_w.sv
module tb_seq_mult_w;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Start = 1'b0;
    logic         Abort = 1'b0;
    logic         Signed_Mode = 1'b0;
    logic [W-1:0] Multiplicand = '0;
    logic [W-1:0] Multiplier = '0;
    logic         Busy, Done, X;
    logic [2*W-1:0] Product;
    logic [W-1:0] Aval, Bval;

    seq_mult_w #(.WIDTH(W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Abort        (Abort),
        .Signed_Mode  (Signed_Mode),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Busy         (Busy),
        .Done         (Done),
        .X            (X),
        .Product      (Product),
        .Aval         (Aval),
        .Bval         (Bval)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;

    logic [16:0] sb_q[$];   // {expected Product, expected X}
    logic        done_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rising Done must match the oldest expected result.
    always @(negedge Clk) begin
        if (Done && !done_q) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: Product=0x%0h with no expected result", Product);
            end else begin
                logic [16:0] e;
                e = sb_q.pop_front();
                check("product", {15'd0, Product, X}, {15'd0, e});
            end
        end
        done_q = Done;
    end

    task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] b, input logic sm,
                          input logic [2*W-1:0] ep, input logic ex, input logic mid_start);
        int edges;
        int exp_lat;
`ifdef SEQ_MULT_SKIP_EN
        exp_lat = W + $countones(b) + 2;
`else
        exp_lat = 2 * W + 2;
`endif
        sb_q.push_back({ep, ex});
        @(negedge Clk);
        Multiplicand = s;
        Multiplier   = b;
        Signed_Mode  = sm;
        Start        = 1'b1;
        @(posedge Clk);
        #1;
        check("accept_busy_done", {30'd0, Busy, Done}, 32'h2);
        @(negedge Clk);
        Start        = 1'b0;
        Multiplicand = ~s;
        Multiplier   = b ^ 8'h5A;
        Signed_Mode  = ~sm;
        edges = 2;
        while (!Done && edges < 100) begin
            @(posedge Clk);
            #1;
            if (mid_start && edges == 6) Start = 1'b1;
            if (mid_start && edges == 8) Start = 1'b0;
            if (!Done) edges++;
        end
        Start = 1'b0;
        check("latency", edges, exp_lat);
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        #12;
        check("reset_outputs", {9'd0, Busy, Done, X, Product[3:0], Aval, Bval},
              32'h0);
        check("reset_product", {16'd0, Product}, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;

        run_op(8'hF9, 8'hFD, 1'b1, 16'h0015, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 16'hFF80, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op(8'h00, 8'h37, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_op(8'h0D, 8'h0B, 1'b0, 16'h008F, 1'b0, 1'b0);
        run_op(8'h7F, 8'h80, 1'b1, 16'hC080, 1'b1, 1'b0);
        run_op(8'hA5, 8'h02, 1'b0, 16'h014A, 1'b0, 1'b0);
        // Start pulsed while busy must not disturb the running multiply
        run_op(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b0, 1'b1);

        // Abort while in DONE drops Done
        @(negedge Clk);
        Abort = 1'b1;
        @(posedge Clk);
        #1;
        Abort = 1'b0;
        check("abort_in_done", {31'd0, Done}, 32'h0);

        // Abort at iteration 3 together with a Start: Abort wins
        @(negedge Clk);
        Multiplicand = 8'h77;
        Multiplier   = 8'hEE;
        Signed_Mode  = 1'b0;
        Start        = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (7) @(posedge Clk);
        #1;
        check("abort_precheck_busy", {31'd0, Busy}, 32'h1);
        Abort = 1'b1;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Abort = 1'b0;
        Start = 1'b0;
        check("abort_state", {14'd0, Busy, Done, X, Aval, Bval}, 32'h0);
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(posedge Clk);
                #1;
                if (Done || Busy) seen++;
            end
            check("abort_stays_idle", seen, 0);
        end

        // Reset asserted at iteration 5
        @(negedge Clk);
        Multiplicand = 8'h33;
        Multiplier   = 8'h55;
        Signed_Mode  = 1'b0;
        Start        = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (11) @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        check("async_reset_ctl", {14'd0, Busy, Done, X, Aval, Bval}, 32'h0);
        check("async_reset_product", {16'd0, Product}, 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        run_op(8'h03, 8'h05, 1'b0, 16'h000F, 1'b0, 1'b0);

        repeat (4) @(negedge Clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
